// File: rtl/pipelined_alu_adder_if.sv
// Operand/result handshake bundle for pipelined_alu_adder.
// master drives operands and consumes results; slave is the adder.
interface pipelined_alu_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [1:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;

  modport master (
    output in_valid, a, b, cin, op, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, a, b, cin, op, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/pipelined_alu_adder.sv
// Chunked carry-pipelined adder/subtractor with NZCV flags.
// One register stage per CHUNK bits; a single advance stalls all stages.
module pipelined_alu_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  pipelined_alu_adder_if.slave bus
);
  localparam int STAGES = WIDTH / CHUNK;

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic             vf_next;

  logic [WIDTH-1:0] opa  [STAGES];
  logic [WIDTH-1:0] opb  [STAGES];
  logic [WIDTH-1:0] part [STAGES];
  logic [WIDTH-1:0] nxt  [STAGES];
  logic [CHUNK:0]   sum  [STAGES];
  logic             cy   [STAGES];
  logic             zi   [STAGES];
  logic             vi   [STAGES];

  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic             c_q [STAGES];
  logic             z_q [STAGES];
  logic             v_q [STAGES];
  logic             vf_q;

  assign adv   = !v_q[STAGES-1] || bus.out_ready;
  assign b_eff = bus.op[1] ? ~bus.b : bus.b;
  // ADD:0, ADC:cin, SUB:1, SBC:cin
  assign c0    = bus.op[0] ? bus.cin : bus.op[1];

  always_comb begin
    opa[0]  = bus.a;
    opb[0]  = b_eff;
    part[0] = '0;
    cy[0]   = c0;
    zi[0]   = 1'b1;
    vi[0]   = bus.in_valid;
    for (int k = 1; k < STAGES; k++) begin
      opa[k]  = a_q[k-1];
      opb[k]  = b_q[k-1];
      part[k] = s_q[k-1];
      cy[k]   = c_q[k-1];
      zi[k]   = z_q[k-1];
      vi[k]   = v_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      sum[k] = {1'b0, opa[k][k*CHUNK +: CHUNK]}
             + {1'b0, opb[k][k*CHUNK +: CHUNK]}
             + {{CHUNK{1'b0}}, cy[k]};
      nxt[k] = part[k];
      nxt[k][k*CHUNK +: CHUNK] = sum[k][CHUNK-1:0];
    end
    // a^b^sum at the MSB recovers the carry into it
    vf_next = sum[STAGES-1][CHUNK]
            ^ opa[STAGES-1][WIDTH-1]
            ^ opb[STAGES-1][WIDTH-1]
            ^ nxt[STAGES-1][WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        z_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end
      vf_q <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= opa[k];
        b_q[k] <= opb[k];
        s_q[k] <= nxt[k];
        c_q[k] <= sum[k][CHUNK];
        z_q[k] <= zi[k] & (sum[k][CHUNK-1:0] == '0);
        v_q[k] <= vi[k];
      end
      vf_q <= vf_next;
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = v_q[STAGES-1];
  assign bus.result    = s_q[STAGES-1];
  assign bus.flags     = {s_q[STAGES-1][WIDTH-1],
                          z_q[STAGES-1],
                          c_q[STAGES-1],
                          vf_q};
endmodule

// File: tb/tb_pipelined_alu_adder.sv
// Bench for pipelined_alu_adder at 32/8, 16/4 and 8/8.
// Expected values come from an arithmetic model and per-DUT FIFOs.
module tb_pipelined_alu_adder;
  logic        clk = 1'b0;
  logic        rst;
  logic        vld;
  logic [31:0] ta;
  logic [31:0] bv;
  logic        tcin;
  logic [1:0]  top;
  logic        ordy;

  int checks = 0;
  int errors = 0;

  bit          use_exp = 1'b0;
  logic [35:0] exp_val = '0;
  logic [35:0] q0[$];
  logic [35:0] q1[$];
  logic [35:0] q2[$];

  pipelined_alu_adder_if #(.WIDTH(32)) i0();
  pipelined_alu_adder_if #(.WIDTH(16)) i1();
  pipelined_alu_adder_if #(.WIDTH(8))  i2();

  assign i0.in_valid  = vld;
  assign i0.a         = ta;
  assign i0.b         = bv;
  assign i0.cin       = tcin;
  assign i0.op        = top;
  assign i0.out_ready = ordy;

  assign i1.in_valid  = vld && i0.in_ready;
  assign i1.a         = ta[15:0];
  assign i1.b         = bv[15:0];
  assign i1.cin       = tcin;
  assign i1.op        = top;
  assign i1.out_ready = 1'b1;

  assign i2.in_valid  = vld && i0.in_ready;
  assign i2.a         = ta[7:0];
  assign i2.b         = bv[7:0];
  assign i2.cin       = tcin;
  assign i2.op        = top;
  assign i2.out_ready = 1'b1;

  pipelined_alu_adder #(.WIDTH(32), .CHUNK(8)) u0 (
    .clk(clk), .rst(rst), .bus(i0));
  pipelined_alu_adder #(.WIDTH(16), .CHUNK(4)) u1 (
    .clk(clk), .rst(rst), .bus(i1));
  pipelined_alu_adder #(.WIDTH(8), .CHUNK(8)) u2 (
    .clk(clk), .rst(rst), .bus(i2));

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Integer-arithmetic reference: {N,Z,C,V, result zero-extended}
  function automatic logic [35:0] model(input int w,
      input logic [31:0] x, input logic [31:0] y,
      input logic ci, input logic [1:0] o);
    longint m, ux, uy, sx, sy, k, r, ex, hi, lo;
    bit c, v;
    m  = (longint'(1) << w) - 1;
    ux = longint'(x) & m;
    uy = longint'(y) & m;
    sx = ux[w-1] ? ux - (m + 1) : ux;
    sy = uy[w-1] ? uy - (m + 1) : uy;
    hi = (m + 1) / 2 - 1;
    lo = -((m + 1) / 2);
    k  = 0;
    if (o[1]) begin
      if (o[0] && !ci) k = 1;
      r  = ux - uy - k;
      c  = ux >= uy + k;
      ex = sx - sy - k;
    end else begin
      if (o[0] && ci) k = 1;
      r  = ux + uy + k;
      c  = r > m;
      ex = sx + sy + k;
    end
    v = (ex > hi) || (ex < lo);
    r = r & m;
    return {r[w-1], r == 0, c, v, 32'(r)};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: score outputs/accepts at negedge, return after posedge
  task automatic tick(output bit acc);
    @(negedge clk);
    acc = vld && i0.in_ready && !rst;
    if (rst) begin
      q0.delete();
      q1.delete();
      q2.delete();
    end else begin
      if (i0.out_valid && ordy) begin
        if (q0.size() == 0) chk("spur32", i0.out_valid, 0);
        else chk("out32", {i0.flags, i0.result}, q0.pop_front());
      end
      if (i1.out_valid) begin
        if (q1.size() == 0) chk("spur16", i1.out_valid, 0);
        else chk("out16", {i1.flags, 16'h0, i1.result},
                 q1.pop_front());
      end
      if (i2.out_valid) begin
        if (q2.size() == 0) chk("spur8", i2.out_valid, 0);
        else chk("out8", {i2.flags, 24'h0, i2.result},
                 q2.pop_front());
      end
      if (acc) begin
        if (use_exp) q0.push_back(exp_val);
        else q0.push_back(model(32, ta, bv, tcin, top));
        q1.push_back(model(16, ta, bv, tcin, top));
        q2.push_back(model(8, ta, bv, tcin, top));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] x, input logic [31:0] y,
                      input logic ci, input logic [1:0] o,
                      output int n);
    bit acc;
    vld = 1'b1; ta = x; bv = y; tcin = ci; top = o;
    n = 0; acc = 1'b0;
    while (!acc && n < 50) begin
      tick(acc);
      n++;
    end
    if (!acc) chk("send_timeout", acc, 1);
  endtask

  task automatic send_x(input logic [31:0] x, input logic [31:0] y,
                        input logic ci, input logic [1:0] o,
                        input logic [35:0] e);
    int n;
    use_exp = 1'b1;
    exp_val = e;
    send(x, y, ci, o, n);
    use_exp = 1'b0;
  endtask

  task automatic drain();
    bit a2;
    int n;
    n = 0;
    vld = 1'b0;
    ordy = 1'b1;
    while ((q0.size() + q1.size() + q2.size()) != 0 && n < 100) begin
      tick(a2);
      n++;
    end
    chk("drain", q0.size() + q1.size() + q2.size(), 0);
    repeat (2) tick(a2);
  endtask

  task automatic latency(input string tag);
    bit a2;
    send_x(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 2'b00,
           {4'b1010, 32'hFFFF_FFFE});
    vld = 1'b0;
    chk({tag, "_w8"}, i2.out_valid, 1);
    chk({tag, "_e0"}, i0.out_valid, 0);
    tick(a2);
    chk({tag, "_e1"}, i0.out_valid, 0);
    tick(a2);
    chk({tag, "_e2"}, i0.out_valid, 0);
    tick(a2);
    chk({tag, "_e3"}, i0.out_valid, 1);
    chk({tag, "_w16"}, i1.out_valid, 1);
    drain();
  endtask

  logic [31:0] sa [12];
  logic [31:0] sb [12];
  logic [31:0] bpa [6];
  logic [31:0] bpb [6];
  logic [1:0]  bpo [6];

  initial begin
    bit          acc;
    int          n;
    int          sent;
    int          stall;
    logic [35:0] hold;

    sa = '{1092657, 2526234, 90221, 12, 15, 100000, 7,
           32'hFFFF_0000, 32'h8000_0000, 255, 65535, 0};
    sb = '{1534, 1274323, 8821000, 10, 15, 99999, 9,
           32'h0001_0000, 32'h8000_0000, 1, 1, 0};
    bpa = '{32'd50, 32'd1, 32'hFFFF_FFFF, 32'd300, 32'd7, 32'hABCD};
    bpb = '{32'd20, 32'd2, 32'd1, 32'd301, 32'd7, 32'h1234};
    bpo = '{2'b00, 2'b10, 2'b00, 2'b10, 2'b11, 2'b01};

    rst = 1'b1; vld = 1'b0; ordy = 1'b1;
    ta = '0; bv = '0; tcin = 1'b0; top = 2'b00;
    repeat (2) tick(acc);
    rst = 1'b0;
    #1;
    chk("rst_ov", i0.out_valid, 0);
    chk("rst_res", i0.result, 0);
    chk("rst_flags", i0.flags, 0);
    chk("rst_ir", i0.in_ready, 1);
    chk("rst_res8", {i2.flags, i2.result}, 0);

    latency("lat");

    send_x(32'hFFFF_FFFF, 32'hFFFF_FAFF, 1'b1, 2'b01,
           {4'b1010, 32'hFFFF_FAFF});
    send_x(32'h7FFF_FFFF, 32'd1, 1'b0, 2'b00,
           {4'b1001, 32'h8000_0000});
    send_x(32'd5, 32'd5, 1'b0, 2'b10, {4'b0110, 32'd0});
    send_x(32'd3, 32'd4, 1'b1, 2'b10, {4'b1000, 32'hFFFF_FFFF});
    send_x(32'd10, 32'd3, 1'b0, 2'b11, {4'b0010, 32'd6});
    drain();

    for (int i = 0; i < 12; i++) begin
      if (i == 0) send_x(sa[i], sb[i], 1'b0, 2'b00, {4'h0, 32'd1094191});
      else if (i == 1) send_x(sa[i], sb[i], 1'b0, 2'b00, {4'h0, 32'd3800557});
      else if (i == 2) send_x(sa[i], sb[i], 1'b0, 2'b00, {4'h0, 32'd8911221});
      else if (i == 3) send_x(sa[i], sb[i], 1'b0, 2'b00, {4'h0, 32'd22});
      else if (i == 4) send_x(sa[i], sb[i], 1'b0, 2'b00, {4'h0, 32'd30});
      else begin
        send(sa[i], sb[i], 1'b0, 2'b00, n);
        chk("b2b", n, 1);
      end
    end
    drain();

    sent = 0; stall = -1; hold = '0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (sent == 6 && stall == 0) break;
      vld  = (sent < 6);
      ta   = bpa[sent < 6 ? sent : 0];
      bv   = bpb[sent < 6 ? sent : 0];
      top  = bpo[sent < 6 ? sent : 0];
      tcin = 1'b0;
      if (stall < 0 && i0.out_valid) begin
        stall = 3;
        hold  = {i0.flags, i0.result};
      end
      ordy = !(stall > 0);
      #1;
      if (stall > 0) begin
        chk("bp_inrdy", i0.in_ready, 0);
        chk("bp_ov", i0.out_valid, 1);
        chk("bp_hold", {i0.flags, i0.result}, hold);
      end
      tick(acc);
      if (acc) sent++;
      if (stall > 0) stall--;
    end
    chk("bp_stalled", stall, 0);
    chk("bp_sent", sent, 6);
    drain();

    for (int i = 0; i < 3; i++) begin
      send(32'd1000 + i, 32'd5, 1'b0, 2'b00, n);
    end
    vld = 1'b0;
    rst = 1'b1;
    tick(acc);
    rst = 1'b0;
    #1;
    chk("mid_rst_ov32", i0.out_valid, 0);
    chk("mid_rst_ov16", i1.out_valid, 0);
    chk("mid_rst_ov8", i2.out_valid, 0);
    latency("rlat");

    vld = 1'b0; acc = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!vld || acc) begin
        vld  = ($urandom_range(3) != 0);
        ta   = pick();
        bv   = pick();
        tcin = 1'($urandom_range(1));
        top  = 2'($urandom_range(3));
      end
      ordy = ($urandom_range(9) < 7);
      tick(acc);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
